// File: rtl/sram_nrmw.sv
// Multi-port register-file SRAM with self-clearing FSM, highest-port-wins write
// arbitration, optional write-to-read forwarding and optional registered reads.
module sram_nrmw #(
  parameter int SRAM_DEPTH = 16,
  parameter int SRAM_INDEX = 4,
  parameter int SRAM_WIDTH = 8,
  parameter int NUM_RD     = 4,
  parameter int NUM_WR     = 8,
  parameter int RD_LATENCY = 0,
  parameter int BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush_i,
  input  logic [NUM_RD*SRAM_INDEX-1:0] addr_rd_i,
  input  logic [NUM_WR*SRAM_INDEX-1:0] addr_wr_i,
  input  logic [NUM_WR-1:0]            we_i,
  input  logic [NUM_WR*SRAM_WIDTH-1:0] data_wr_i,
  output logic [NUM_RD*SRAM_WIDTH-1:0] data_rd_o,
  output logic                         ready_o,
  output logic                         wr_conflict_o
);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_e;

  localparam logic [SRAM_INDEX-1:0] PTR_LAST = SRAM_INDEX'(SRAM_DEPTH - 1);
  localparam logic [SRAM_INDEX-1:0] PTR_ONE  = SRAM_INDEX'(1);

  state_e                        state_q, state_d;
  logic [SRAM_INDEX-1:0]         clr_ptr_q, clr_ptr_d;
  logic [SRAM_WIDTH-1:0]         mem_q [SRAM_DEPTH];
  logic [SRAM_WIDTH-1:0]         mem_d [SRAM_DEPTH];
  logic                          wr_conflict_q, wr_conflict_d;
  logic [NUM_RD*SRAM_WIDTH-1:0]  rd_data_q, rd_data_d;
  logic [NUM_WR-1:0]             wen_s;
  logic                          conflict_s;
  logic [NUM_RD*SRAM_WIDTH-1:0]  rd_pre_s, rd_fwd_s, rd_sel_s, rd_comb_s;

  // Writes only land in READY, and a flush or reset in the same cycle discards them.
  always_comb begin
    if (state_q == READY && !flush_i && !reset) begin
      wen_s = we_i;
    end else begin
      wen_s = '0;
    end
  end

  // Any pair of enabled writes to one address is a collision.
  always_comb begin
    conflict_s = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        conflict_s = conflict_s | (wen_s[i] & wen_s[j] &
          (addr_wr_i[i*SRAM_INDEX +: SRAM_INDEX] == addr_wr_i[j*SRAM_INDEX +: SRAM_INDEX]));
      end
    end
    wr_conflict_d = conflict_s;
  end

  // Per read port: stored value and forwarded value (later ports override earlier).
  always_comb begin
    rd_pre_s = '0;
    rd_fwd_s = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_pre_s[k*SRAM_WIDTH +: SRAM_WIDTH] = mem_q[addr_rd_i[k*SRAM_INDEX +: SRAM_INDEX]];
      rd_fwd_s[k*SRAM_WIDTH +: SRAM_WIDTH] = rd_pre_s[k*SRAM_WIDTH +: SRAM_WIDTH];
      for (int w = 0; w < NUM_WR; w++) begin
        rd_fwd_s[k*SRAM_WIDTH +: SRAM_WIDTH] =
          (wen_s[w] && (addr_wr_i[w*SRAM_INDEX +: SRAM_INDEX] == addr_rd_i[k*SRAM_INDEX +: SRAM_INDEX]))
            ? data_wr_i[w*SRAM_WIDTH +: SRAM_WIDTH]
            : rd_fwd_s[k*SRAM_WIDTH +: SRAM_WIDTH];
      end
    end
  end

  // Next state and clear pointer.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      CLEAR: begin
        if (flush_i) begin
          clr_ptr_d = '0;
        end else if (clr_ptr_q == PTR_LAST) begin
          state_d   = READY;
          clr_ptr_d = clr_ptr_q + PTR_ONE;
        end else begin
          clr_ptr_d = clr_ptr_q + PTR_ONE;
        end
      end
      READY: begin
        if (flush_i) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end else begin
          state_d   = READY;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_ptr_d = '0;
      end
    endcase
  end

  // Read-data selection; reads are forced to zero whenever the array is clearing.
  always_comb begin
    if (BYPASS != 0) begin
      rd_sel_s = rd_fwd_s;
    end else begin
      rd_sel_s = rd_pre_s;
    end
    if (state_q == READY) begin
      rd_comb_s = rd_sel_s;
    end else begin
      rd_comb_s = '0;
    end
    if (state_q == READY && state_d == READY) begin
      rd_data_d = rd_sel_s;
    end else begin
      rd_data_d = '0;
    end
  end

  // Array update: one entry zeroed per CLEAR cycle, otherwise ascending port order so the highest port wins.
  always_comb begin
    mem_d = mem_q;
    if (state_q == CLEAR) begin
      mem_d[clr_ptr_q] = '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        mem_d[addr_wr_i[w*SRAM_INDEX +: SRAM_INDEX]] = wen_s[w]
          ? data_wr_i[w*SRAM_WIDTH +: SRAM_WIDTH]
          : mem_d[addr_wr_i[w*SRAM_INDEX +: SRAM_INDEX]];
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= CLEAR;
      clr_ptr_q     <= '0;
      wr_conflict_q <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      clr_ptr_q     <= clr_ptr_d;
      wr_conflict_q <= wr_conflict_d;
      rd_data_q     <= rd_data_d;
    end
  end

  // Storage array; contents after reset are irrelevant since a full clear follows.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign data_rd_o     = (RD_LATENCY != 0) ? rd_data_q : rd_comb_s;
  assign ready_o       = (state_q == READY);
  assign wr_conflict_o = wr_conflict_q;

endmodule

// File: tb/tb_sram_nrmw.sv
// Four parameterisations of sram_nrmw driven by shared stimulus and checked every
// cycle against an array-level model, plus literal checks of key scenarios.
module tb_sram_nrmw;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, flush;
  logic [7:0] we;
  logic [3:0] wa [8];
  logic [7:0] wd [8];
  logic [3:0] ra [4];

  logic [31:0] awr16, ard16_dummy;
  logic [15:0] ard16;
  logic [63:0] dwr64;
  logic [8:0]  awr8;
  logic [5:0]  ard8;
  logic [23:0] dwr24;

  always_comb begin
    awr16 = '0; ard16 = '0; dwr64 = '0; awr8 = '0; ard8 = '0; dwr24 = '0;
    ard16_dummy = '0;
    for (int i = 0; i < 8; i++) begin
      awr16[i*4 +: 4] = wa[i];
      dwr64[i*8 +: 8] = wd[i];
    end
    for (int i = 0; i < 4; i++) ard16[i*4 +: 4] = ra[i];
    for (int i = 0; i < 3; i++) begin
      awr8[i*3 +: 3]  = wa[i][2:0];
      dwr24[i*8 +: 8] = wd[i];
    end
    for (int i = 0; i < 2; i++) ard8[i*3 +: 3] = ra[i][2:0];
  end

  logic [31:0] rd_a, rd_b, rd_c;
  logic [15:0] rd_d;
  logic rdy_a, rdy_b, rdy_c, rdy_d, cf_a, cf_b, cf_c, cf_d;

  sram_nrmw #(.SRAM_DEPTH(16), .SRAM_INDEX(4), .SRAM_WIDTH(8), .NUM_RD(4), .NUM_WR(8),
              .RD_LATENCY(0), .BYPASS(1)) u_a (
    .clk(clk), .reset(reset), .flush_i(flush), .addr_rd_i(ard16), .addr_wr_i(awr16),
    .we_i(we), .data_wr_i(dwr64), .data_rd_o(rd_a), .ready_o(rdy_a), .wr_conflict_o(cf_a));
  sram_nrmw #(.SRAM_DEPTH(16), .SRAM_INDEX(4), .SRAM_WIDTH(8), .NUM_RD(4), .NUM_WR(8),
              .RD_LATENCY(0), .BYPASS(0)) u_b (
    .clk(clk), .reset(reset), .flush_i(flush), .addr_rd_i(ard16), .addr_wr_i(awr16),
    .we_i(we), .data_wr_i(dwr64), .data_rd_o(rd_b), .ready_o(rdy_b), .wr_conflict_o(cf_b));
  sram_nrmw #(.SRAM_DEPTH(16), .SRAM_INDEX(4), .SRAM_WIDTH(8), .NUM_RD(4), .NUM_WR(8),
              .RD_LATENCY(1), .BYPASS(0)) u_c (
    .clk(clk), .reset(reset), .flush_i(flush), .addr_rd_i(ard16), .addr_wr_i(awr16),
    .we_i(we), .data_wr_i(dwr64), .data_rd_o(rd_c), .ready_o(rdy_c), .wr_conflict_o(cf_c));
  sram_nrmw #(.SRAM_DEPTH(8), .SRAM_INDEX(3), .SRAM_WIDTH(8), .NUM_RD(2), .NUM_WR(3),
              .RD_LATENCY(1), .BYPASS(1)) u_d (
    .clk(clk), .reset(reset), .flush_i(flush), .addr_rd_i(ard8), .addr_wr_i(awr8),
    .we_i(we[2:0]), .data_wr_i(dwr24), .data_rd_o(rd_d), .ready_o(rdy_d), .wr_conflict_o(cf_d));

  // Behavioural model: per configuration, cycles of clearing left, array contents,
  // expected conflict flag and expected registered read data.
  int depth [4] = '{16, 16, 16, 8};
  int nrd   [4] = '{4, 4, 4, 2};
  int nwr   [4] = '{8, 8, 8, 3};
  int lat   [4] = '{0, 0, 1, 1};
  int byp   [4] = '{1, 0, 0, 1};
  logic [7:0] mm  [4][16];
  logic [7:0] mrd [4][4];
  int         clear_left [4];
  bit         mconf [4];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] win(input int c, input int a);
    logic [8:0] r;
    r = '0;
    for (int w = 0; w < nwr[c]; w++)
      if (we[w] && (int'(wa[w]) % depth[c]) == a) r = {1'b1, wd[w]};
    return r;
  endfunction

  function automatic logic [7:0] exp_rd(input int c, input int k);
    int a;
    logic [8:0] h;
    a = int'(ra[k]) % depth[c];
    if (lat[c] != 0) return mrd[c][k];
    if (clear_left[c] > 0) return 8'h00;
    h = win(c, a);
    if (byp[c] != 0 && !flush && !reset && h[8]) return h[7:0];
    return mm[c][a];
  endfunction

  function automatic logic [7:0] act_rd(input int c, input int k);
    case (c)
      0: return rd_a[k*8 +: 8];
      1: return rd_b[k*8 +: 8];
      2: return rd_c[k*8 +: 8];
      default: return rd_d[k*8 +: 8];
    endcase
  endfunction

  function automatic logic act_rdy(input int c);
    case (c)
      0: return rdy_a;
      1: return rdy_b;
      2: return rdy_c;
      default: return rdy_d;
    endcase
  endfunction

  function automatic logic act_cf(input int c);
    case (c)
      0: return cf_a;
      1: return cf_b;
      2: return cf_c;
      default: return cf_d;
    endcase
  endfunction

  task automatic wipe(input int c);
    for (int a = 0; a < 16; a++) mm[c][a] = 8'h00;
    for (int k = 0; k < 4; k++) mrd[c][k] = 8'h00;
    mconf[c] = 1'b0;
  endtask

  task automatic model_step();
    int cnt [16];
    logic [8:0] h;
    int a;
    for (int c = 0; c < 4; c++) begin
      if (reset) begin
        clear_left[c] = depth[c];
        wipe(c);
      end else if (clear_left[c] > 0) begin
        mconf[c] = 1'b0;
        for (int k = 0; k < 4; k++) mrd[c][k] = 8'h00;
        clear_left[c] = flush ? depth[c] : clear_left[c] - 1;
      end else if (flush) begin
        clear_left[c] = depth[c];
        wipe(c);
      end else begin
        for (int i = 0; i < 16; i++) cnt[i] = 0;
        for (int w = 0; w < nwr[c]; w++) if (we[w]) cnt[int'(wa[w]) % depth[c]]++;
        mconf[c] = 1'b0;
        for (int i = 0; i < 16; i++) if (cnt[i] >= 2) mconf[c] = 1'b1;
        for (int k = 0; k < nrd[c]; k++) begin
          a = int'(ra[k]) % depth[c];
          h = win(c, a);
          mrd[c][k] = (byp[c] != 0 && h[8]) ? h[7:0] : mm[c][a];
        end
        for (int i = 0; i < depth[c]; i++) begin
          h = win(c, i);
          if (h[8]) mm[c][i] = h[7:0];
        end
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("cfg%0d ready", c), {31'd0, act_rdy(c)}, {31'd0, clear_left[c] == 0});
      chk($sformatf("cfg%0d conflict", c), {31'd0, act_cf(c)}, {31'd0, mconf[c]});
      for (int k = 0; k < nrd[c]; k++)
        chk($sformatf("cfg%0d rd%0d", c, k), {24'd0, act_rd(c, k)}, {24'd0, exp_rd(c, k)});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    we = 8'h00;
    flush = 1'b0;
    for (int i = 0; i < 8; i++) begin wa[i] = 4'd0; wd[i] = 8'h00; end
    for (int i = 0; i < 4; i++) ra[i] = 4'd0;
  endtask

  int cnt_cyc;

  initial begin
    reset = 1'b1;
    idle_inputs();
    for (int c = 0; c < 4; c++) begin clear_left[c] = depth[c]; wipe(c); end
    tick();
    tick();

    // Reset state
    settle();
    chk("reset ready", {31'd0, rdy_a}, 32'd0);
    chk("reset conflict", {31'd0, cf_a}, 32'd0);
    chk("reset rd_c", rd_c, 32'h0);
    tick();

    // Clear length after reset release, and all-zero array afterwards
    reset = 1'b0;
    ra[0] = 4'd1; ra[1] = 4'd7; ra[2] = 4'd12; ra[3] = 4'd15;
    cnt_cyc = 0;
    settle();
    while (!rdy_a && cnt_cyc < 100) begin tick(); cnt_cyc++; settle(); end
    chk("clear cycles", cnt_cyc, 32'd16);
    chk("cleared reads", rd_a, 32'h0);
    tick();

    // Same-cycle forwarding vs stored value
    idle_inputs();
    we = 8'h01; wa[0] = 4'd9; wd[0] = 8'h3C; ra[3] = 4'd9;
    settle();
    chk("bypass rd3", {24'd0, rd_a[31:24]}, 32'h3C);
    chk("nobypass rd3", {24'd0, rd_b[31:24]}, 32'h00);
    tick();

    // Collision: highest port wins, one-cycle conflict pulse
    idle_inputs();
    we = 8'h44; wa[2] = 4'd5; wd[2] = 8'hAA; wa[6] = 4'd5; wd[6] = 8'h55; ra[0] = 4'd5;
    settle();
    tick();
    we = 8'h00;
    settle();
    chk("collision data", {24'd0, rd_a[7:0]}, 32'h55);
    chk("conflict pulse", {31'd0, cf_a}, 32'd1);
    tick();
    settle();
    chk("conflict cleared", {31'd0, cf_a}, 32'd0);
    tick();

    // Registered read-first
    idle_inputs();
    we = 8'h01; wa[0] = 4'd2; wd[0] = 8'h11;
    settle(); tick();
    we = 8'h80; wa[7] = 4'd2; wd[7] = 8'h22; ra[0] = 4'd2;
    settle(); tick();
    we = 8'h00;
    settle();
    chk("read-first old", {24'd0, rd_c[7:0]}, 32'h11);
    tick();
    settle();
    chk("read-first new", {24'd0, rd_c[7:0]}, 32'h22);
    tick();

    // Flush discards its same-cycle write and re-clears the array
    idle_inputs();
    we = 8'h01; wa[0] = 4'd4; wd[0] = 8'hF0;
    settle(); tick();
    flush = 1'b1; wd[0] = 8'hAA;
    settle(); tick();
    idle_inputs();
    ra[0] = 4'd4;
    cnt_cyc = 0;
    settle();
    while (!rdy_a && cnt_cyc < 100) begin cnt_cyc++; tick(); settle(); end
    chk("flush low cycles", cnt_cyc, 32'd16);
    chk("flushed addr4", {24'd0, rd_a[7:0]}, 32'h00);
    tick();

    // Reset mid-clear restarts the small configuration's clear
    idle_inputs();
    flush = 1'b1;
    settle(); tick();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin settle(); tick(); end
    reset = 1'b1;
    settle(); tick();
    reset = 1'b0;
    cnt_cyc = 0;
    settle();
    while (!rdy_d && cnt_cyc < 100) begin tick(); cnt_cyc++; settle(); end
    chk("restart clear cycles", cnt_cyc, 32'd8);
    tick();

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      int narrow;
      reset = ($urandom_range(0, 249) == 0);
      flush = ($urandom_range(0, 79) == 0);
      narrow = $urandom_range(0, 1);
      for (int w = 0; w < 8; w++) begin
        we[w] = ($urandom_range(0, 2) == 0);
        wa[w] = narrow != 0 ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
        wd[w] = 8'($urandom);
      end
      for (int k = 0; k < 4; k++)
        ra[k] = narrow != 0 ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      settle();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_nrmw.md
SRAM_NRMW -- requirements
Module: sram_nrmw

Interface
Parameters (name, default, meaning):
REQ-001 SRAM_DEPTH, 16, number of entries; SHALL be greater than or equal to 2.
REQ-002 SRAM_INDEX, 4, address width; SHALL equal clog2(SRAM_DEPTH).
REQ-003 SRAM_WIDTH, 8, data width in bits.
REQ-004 NUM_RD, 4, read port count; SHALL be in the range 1..8.
REQ-005 NUM_WR, 8, write port count; SHALL be in the range 1..8.
REQ-006 RD_LATENCY, 0, read mode: 0 is combinational, 1 is registered.
REQ-007 BYPASS, 1, write-to-read forwarding: 1 enables it, 0 disables it.

Ports (name, direction, width, meaning):
REQ-008 clk, in, 1, the single clock; all state SHALL update on its rising edge.
REQ-009 reset, in, 1, synchronous active-high reset.
REQ-010 flush_i, in, 1, one-cycle request to re-clear the whole array.
REQ-011 addr_rd_i, in, NUM_RD*SRAM_INDEX, packed read addresses; port k occupies slice [k*SRAM_INDEX +: SRAM_INDEX].
REQ-012 addr_wr_i, in, NUM_WR*SRAM_INDEX, packed write addresses, sliced the same way.
REQ-013 we_i, in, NUM_WR, per-port write enables.
REQ-014 data_wr_i, in, NUM_WR*SRAM_WIDTH, packed write data.
REQ-015 data_rd_o, out, NUM_RD*SRAM_WIDTH, packed read data.
REQ-016 ready_o, out, 1, high when the array is in the READY state.
REQ-017 wr_conflict_o, out, 1, registered flag: two or more enabled writes targeted one address in the previous cycle.

Function
REQ-018 The FSM SHALL have two states: CLEAR and READY; a clear pointer clr_ptr of width SRAM_INDEX SHALL accompany it.
REQ-019 In CLEAR, entry clr_ptr SHALL be written with 0 each cycle; clr_ptr SHALL then increment.
REQ-020 When clr_ptr equals SRAM_DEPTH-1 in CLEAR, the next state SHALL be READY.
- The clear therefore takes exactly SRAM_DEPTH cycles.
REQ-021 In CLEAR: ready_o=0, all we_i SHALL be ignored, and data_rd_o SHALL be all zeros.
REQ-022 In READY, flush_i=1 SHALL cause the next state to be CLEAR with clr_ptr=0.
- Writes presented in the same cycle as flush_i SHALL be discarded.
REQ-023 flush_i asserted while in CLEAR SHALL restart clr_ptr at 0.
REQ-024 In READY, each port w with we_i[w]=1 SHALL write its data to its address at the clock edge.
REQ-025 When several enabled ports share an address, the highest-numbered port SHALL win; all losing data SHALL be dropped.
REQ-026 wr_conflict_o SHALL be 1 in the cycle after any same-address enabled collision in READY, and 0 otherwise.
REQ-027 RD_LATENCY=0: data_rd_o[k] SHALL be a combinational read of entry addr_rd_i[k].
- With BYPASS=1, if any enabled write in the same cycle targets that address, the read SHALL return the winning write data instead of the stored value.
REQ-028 RD_LATENCY=1: data_rd_o[k] SHALL be registered, showing the value for the address presented one cycle earlier.
- With BYPASS=1 the registered value SHALL include that cycle's winning write (write-first).
- With BYPASS=0 it SHALL return the pre-write value (read-first).
REQ-029 RD_LATENCY=0 with BYPASS=0: a read SHALL return the stored value; a same-cycle write SHALL become visible the following cycle.
REQ-030 Read ports SHALL be independent; any number of ports may read the same address in the same cycle.
REQ-031 Addresses SHALL always be in range, because SRAM_DEPTH=2^SRAM_INDEX; clr_ptr SHALL wrap to 0 after the last entry.

Reset
REQ-032 reset=1 SHALL force state CLEAR and clr_ptr=0; reset overrides flush_i and all writes.
- Registered data_rd_o SHALL be 0.
- wr_conflict_o SHALL be 0.
- ready_o SHALL be 0.
REQ-033 While reset is held, clr_ptr SHALL stay at 0; clearing SHALL begin on the first cycle after reset deasserts.
- ready_o SHALL rise SRAM_DEPTH cycles after that first cycle.
REQ-034 reset asserted in READY or partway through a CLEAR SHALL restart the full clear sequence.

Verification
REQ-035 Defaults: deassert reset, count cycles -> ready_o rises after exactly 16 cycles; every read port returns 8'h00.
REQ-036 Defaults, in READY: ports 2 and 6 both write address 5 with 8'hAA and 8'h55 -> read of address 5 returns 8'h55, and wr_conflict_o=1 for exactly one cycle.
REQ-037 RD_LATENCY=0, BYPASS=1: port 0 writes 8'h3C to address 9 while read port 3 reads address 9 in the same cycle -> data_rd_o[3]=8'h3C in that cycle; with BYPASS=0 it returns the old value 8'h00.
REQ-038 RD_LATENCY=1, BYPASS=0: address 2 holds 8'h11, port 7 writes 8'h22 to address 2, and address 2 is read in the same cycle -> output next cycle is 8'h11, and 8'h22 on the following read.
REQ-039 Defaults, with address 4 holding 8'hF0: pulse flush_i together with a write to address 4 -> ready_o=0 for 16 cycles, the write is discarded, and address 4 reads 8'h00 afterward.
REQ-040 NUM_RD=2, NUM_WR=3, SRAM_DEPTH=8: assert reset at clr_ptr=3 of a flush -> the clear restarts from 0, and ready_o rises 8 cycles after reset deasserts.
